// File: rtl/step_dir_follower.sv
// step_dir_follower
//   Drives a stepper driver's step/dir pins so that an internal step count
//   ("actual") follows a target position coming from a same-clock quadrature
//   counter. It enforces the driver's timing: dir is stable DIR_SETUP cycles
//   before a step rising edge, step stays high STEP_HIGH cycles, and step
//   stays low at least STEP_LOW cycles after each pulse.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   asynchronous, active-high reset
//   target     in   [POS_BITS] desired position (used synchronously)
//   step       out  registered step pulse
//   dir        out  registered direction, 1 = forward (increment)
//   actual     out  [POS_BITS] registered count of steps issued (modulo)
//   at_target  out  combinational actual == target
//
// Handshake: none. target is sampled only when the follower is idle; a pulse
// that has started always runs to completion.
module step_dir_follower #(
    parameter int POS_BITS  = 5,
    parameter int DIR_SETUP = 2,
    parameter int STEP_HIGH = 3,
    parameter int STEP_LOW  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [POS_BITS-1:0] target,
    output logic                step,
    output logic                dir,
    output logic [POS_BITS-1:0] actual,
    output logic                at_target
);

    localparam int MAX_A = (DIR_SETUP > STEP_HIGH) ? DIR_SETUP : STEP_HIGH;
    localparam int MAX_N = (MAX_A > STEP_LOW) ? MAX_A : STEP_LOW;
    localparam int TW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    // Timer is loaded with N-1 on state entry so the state lasts N cycles.
    localparam logic [TW-1:0] SETUP_LOAD = TW'(DIR_SETUP - 1);
    localparam logic [TW-1:0] HIGH_LOAD  = TW'(STEP_HIGH - 1);
    localparam logic [TW-1:0] LOW_LOAD   = TW'(STEP_LOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [TW-1:0]       timer_q,  timer_d;
    logic                step_q,   step_d;
    logic                dir_q,    dir_d;
    logic [POS_BITS-1:0] actual_q, actual_d;

    logic [POS_BITS-1:0] diff;
    logic                new_dir;

    // Modular error. A clear MSB means the forward path is strictly shorter;
    // the exact half-range value has its MSB set and therefore goes reverse.
    assign diff    = target - actual_q;
    assign new_dir = ~diff[POS_BITS-1];

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        step_d   = step_q;
        dir_d    = dir_q;
        actual_d = actual_q;
        case (state_q)
            ST_IDLE: begin
                step_d = 1'b0;
                if (diff != '0) begin
                    if (new_dir != dir_q) begin
                        dir_d   = new_dir;
                        state_d = ST_SETUP;
                        timer_d = SETUP_LOAD;
                    end else begin
                        state_d = ST_HIGH;
                        timer_d = HIGH_LOAD;
                        step_d  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (timer_q == '0) begin
                    state_d = ST_HIGH;
                    timer_d = HIGH_LOAD;
                    step_d  = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_HIGH: begin
                if (timer_q == '0) begin
                    // The step counts on its falling edge.
                    state_d  = ST_LOW;
                    timer_d  = LOW_LOAD;
                    step_d   = 1'b0;
                    actual_d = dir_q ? (actual_q + POS_BITS'(1))
                                     : (actual_q - POS_BITS'(1));
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_LOW: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                step_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            actual_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            actual_q <= actual_d;
        end
    end

    assign step      = step_q;
    assign dir       = dir_q;
    assign actual    = actual_q;
    assign at_target = (actual_q == target);

endmodule

// File: tb/tb_step_dir_follower.sv
// Testbench for step_dir_follower: directed scenarios followed by random
// retargeting, all checked cycle by cycle against a pulse-schedule model.
module tb_step_dir_follower;

    localparam int PB  = 5;
    localparam int DS  = 2;
    localparam int SH  = 3;
    localparam int SL  = 2;
    localparam int MOD = 1 << PB;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PB-1:0] target = '0;
    logic          step;
    logic          dir;
    logic [PB-1:0] actual;
    logic          at_target;

    always #5 clk = ~clk;

    step_dir_follower #(
        .POS_BITS (PB),
        .DIR_SETUP(DS),
        .STEP_HIGH(SH),
        .STEP_LOW (SL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .target   (target),
        .step     (step),
        .dir      (dir),
        .actual   (actual),
        .at_target(at_target)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- reference model ----------------
    // Event schedule: at a decision cycle the model books when dir flips,
    // which cycles step is high, when actual moves and when the next
    // decision happens.
    int m_actual, m_dir, next_dec;
    int hi_start, hi_end, dir_at, dir_new, act_at, act_new;

    // ---------------- pin monitor ----------------
    int rises, hi_len, last_dir_chg;
    logic prev_step, prev_dir;
    int rise_q[$];
    int gap_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_actual = 0;
        m_dir    = 0;
        next_dec = cyc + 1;
        hi_start = -10;
        hi_end   = -20;
        dir_at   = -1;
        act_at   = -1;
    endtask

    task automatic model_decide();
        int d, nd, delay;
        d = (int'(target) - m_actual + MOD) % MOD;
        if (d == 0) begin
            next_dec = cyc + 1;
        end else begin
            // Shortest path; an exact tie goes reverse.
            nd    = (d < MOD - d) ? 1 : 0;
            delay = (nd != m_dir) ? DS : 0;
            if (nd != m_dir) begin
                dir_at  = cyc + 1;
                dir_new = nd;
            end
            hi_start = cyc + 1 + delay;
            hi_end   = cyc + delay + SH;
            act_at   = cyc + delay + SH + 1;
            act_new  = (m_actual + (nd == 1 ? 1 : MOD - 1)) % MOD;
            next_dec = cyc + 1 + delay + SH + SL;
        end
    endtask

    task automatic clear_mon();
        rises = 0;
        rise_q.delete();
        gap_q.delete();
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic [PB-1:0] tgt, input logic r);
        logic exp_step;
        @(posedge clk);
        cyc++;
        #1;
        target = tgt;
        reset  = r;
        #1;
        if (r) model_reset();
        else begin
            if (dir_at == cyc) m_dir = dir_new;
            if (act_at == cyc) m_actual = act_new;
        end
        exp_step = (cyc >= hi_start) && (cyc <= hi_end);
        check("step", step, exp_step);
        check("dir", dir, m_dir[0]);
        check("actual", actual, m_actual);
        check("at_target", at_target, (m_actual == int'(target)));
        if (!r) begin
            if (step && !prev_step) begin
                rises++;
                rise_q.push_back(cyc);
                gap_q.push_back(cyc - last_dir_chg);
            end
            if (!step && prev_step) check("high_width", hi_len, SH);
            hi_len = step ? hi_len + 1 : 0;
            if (dir !== prev_dir) last_dir_chg = cyc;
            if (cyc == next_dec) model_decide();
        end else begin
            hi_len = 0;
        end
        prev_step = step;
        prev_dir  = dir;
    endtask

    task automatic do_reset();
        repeat (3) tick('0, 1'b1);
        tick('0, 1'b0);
        clear_mon();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_apply;
        int guard;
        logic [PB-1:0] tgt;
        prev_step = 1'b0;
        prev_dir  = 1'b0;
        hi_len = 0;
        last_dir_chg = 0;
        model_reset();
        clear_mon();

        // 1: reset values, idle for 50 cycles
        do_reset();
        check("t1_step", step, 0);
        check("t1_actual", actual, 0);
        check("t1_at_target", at_target, 1);
        repeat (50) tick('0, 1'b0);
        check("t1_no_pulses", rises, 0);

        // 2: forward 3 steps with dir setup
        clear_mon();
        repeat (40) tick(5'd3, 1'b0);
        check("t2_rises", rises, 3);
        if (rise_q.size() >= 3) begin
            check("t2_setup_gap", gap_q[0], DS);
            check("t2_period1", rise_q[1] - rise_q[0], SH + SL + 1);
            check("t2_period2", rise_q[2] - rise_q[1], SH + SL + 1);
        end
        check("t2_actual", actual, 3);
        check("t2_dir", dir, 1);
        check("t2_at_target", at_target, 1);

        // 3: wrap reverse from actual=0/dir=1
        do_reset();
        repeat (20) tick(5'd31, 1'b0);
        repeat (20) tick(5'd0, 1'b0);
        check("t3_pre_dir", dir, 1);
        check("t3_pre_actual", actual, 0);
        clear_mon();
        repeat (30) tick(5'd31, 1'b0);
        check("t3_rises", rises, 1);
        if (gap_q.size() >= 1) check("t3_setup_gap", gap_q[0], DS);
        check("t3_actual", actual, 31);
        check("t3_dir", dir, 0);

        // 4: half range goes reverse without setup
        do_reset();
        tick(5'd16, 1'b0);
        t_apply = cyc;
        repeat (120) tick(5'd16, 1'b0);
        check("t4_rises", rises, 16);
        if (rise_q.size() >= 1) check("t4_first_rise", rise_q[0] - t_apply, 1);
        check("t4_dir", dir, 0);
        check("t4_actual", actual, 16);
        check("t4_at_target", at_target, 1);

        // 5: retarget during the second pulse
        do_reset();
        guard = 0;
        while (rises < 2 && guard < 60) begin
            tick(5'd5, 1'b0);
            guard++;
        end
        check("t5_reach_pulse2", rises >= 2, 1);
        repeat (40) tick(5'd1, 1'b0);
        check("t5_rises", rises, 3);
        if (gap_q.size() >= 3) check("t5_rev_setup_gap", gap_q[2], DS);
        check("t5_actual", actual, 1);
        check("t5_dir", dir, 0);

        // 6: asynchronous reset in the middle of a HIGH cycle
        clear_mon();
        guard = 0;
        while (step !== 1'b1 && guard < 60) begin
            tick(5'd10, 1'b0);
            guard++;
        end
        check("t6_reach_high", step, 1);
        #1;
        reset = 1'b1;
        #1;
        check("t6_async_step", step, 0);
        check("t6_async_actual", actual, 0);
        check("t6_async_dir", dir, 0);
        repeat (2) tick(5'd2, 1'b1);
        clear_mon();
        repeat (30) tick(5'd2, 1'b0);
        check("t6_rises", rises, 2);
        if (gap_q.size() >= 1) check("t6_setup_gap", gap_q[0], DS);
        check("t6_actual", actual, 2);

        // random retargeting, including mid-pulse changes and long holds
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       tgt = actual + PB'($urandom_range(0, 2));
                1:       tgt = actual - PB'($urandom_range(0, 2));
                2:       tgt = actual + PB'(MOD / 2);
                default: tgt = PB'($urandom_range(0, MOD - 1));
            endcase
            repeat ($urandom_range(1, 40)) tick(tgt, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
